// File: rtl/cdc_handshake_rx.sv
// Destination side of a toggle/handshake clock-domain crossing: synchronizes the request toggle,
// captures the quasi-static data bus and returns an ack toggle. Optional sticky error: CDC_HS_RX_ERR_EN.
module cdc_handshake_rx #(
   parameter int unsigned     DW      = 32,
   parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
   parameter int unsigned     STAGE   = 3
) (
   input  logic           I_CLK,
   input  logic           I_RST_N,
   input  logic           I_REQ_TGL,
   input  logic [DW-1:0]  I_DATA,
   input  logic           I_READY,
   output logic [DW-1:0]  O_DATA,
   output logic           O_VALID,
   output logic           O_ACK_TGL
`ifdef CDC_HS_RX_ERR_EN
   ,
   output logic           O_ERR,
   input  logic           I_ERR_CLR
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   logic [STAGE-1:0] sync_q;
   logic             req_s;
   logic             req_d_q;
   logic             req_edge_s;

   state_t           state_q, state_d;
   logic [DW-1:0]    data_q, data_d;
   logic             valid_q, valid_d;
   logic             ack_q, ack_d;

   assign req_s      = sync_q[STAGE-1];
   assign req_edge_s = req_s ^ req_d_q;

   // Only the request toggle crosses domains; the data bus is sampled once the edge is seen.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         sync_q  <= {STAGE{1'b0}};
         req_d_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGE-2:0], I_REQ_TGL};
         req_d_q <= req_s;
      end
   end

   // Handshake FSM state and registered outputs.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q <= ST_IDLE;
         data_q  <= RST_VAL;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state logic; an edge seen in VALID is dropped without touching the held word.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      ack_d   = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (req_edge_s) begin
               data_d  = I_DATA;
               valid_d = 1'b1;
               state_d = ST_VALID;
            end else begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_VALID: begin
            if (I_READY) begin
               valid_d = 1'b0;
               ack_d   = ~ack_q;
               state_d = ST_IDLE;
            end else begin
               valid_d = 1'b1;
               state_d = ST_VALID;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign O_DATA    = data_q;
   assign O_VALID   = valid_q;
   assign O_ACK_TGL = ack_q;

`ifdef CDC_HS_RX_ERR_EN
   logic viol_s;
   logic err_q, err_d;

   assign viol_s = req_edge_s && (state_q == ST_VALID);

   // Sticky error: a new violation beats a simultaneous clear.
   always_comb begin
      err_d = err_q;
      if (viol_s) begin
         err_d = 1'b1;
      end else if (I_ERR_CLR) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign O_ERR = err_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed self-checking bench for cdc_handshake_rx (DW=32, STAGE=3, RST_VAL=0), 25 MHz I_CLK.
`timescale 1ns/1ps
module tb_cdc_handshake_rx;

   logic        clk_s = 1'b0;
   logic        src_clk_s = 1'b0;
   logic        rst_n_s;
   logic        req_s;
   logic [31:0] data_in_s;
   logic        ready_s;
   logic [31:0] data_out_s;
   logic        valid_s;
   logic        ack_s;
`ifdef CDC_HS_RX_ERR_EN
   logic        err_s;
   logic        err_clr_s;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic        exp_ack_r = 1'b0;
   logic [31:0] words_r [30];
   int          ack_cnt_r = 0;
   logic        stream_done_r = 1'b0;

   always #20 clk_s = ~clk_s;
   always #25 src_clk_s = ~src_clk_s;

   cdc_handshake_rx #(.DW(32), .RST_VAL(32'h0000_0000), .STAGE(3)) u_dut (
      .I_CLK     (clk_s),
      .I_RST_N   (rst_n_s),
      .I_REQ_TGL (req_s),
      .I_DATA    (data_in_s),
      .I_READY   (ready_s),
      .O_DATA    (data_out_s),
      .O_VALID   (valid_s),
      .O_ACK_TGL (ack_s)
`ifdef CDC_HS_RX_ERR_EN
      ,
      .O_ERR     (err_s),
      .I_ERR_CLR (err_clr_s)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n;
      n = 0;
      while (valid_s !== 1'b1 && n < limit) begin
         @(posedge clk_s); #1;
         n++;
      end
      check_val(tag, {31'd0, valid_s}, 32'd1);
   endtask

   task automatic send_req(input logic [31:0] d);
      @(negedge clk_s);
      data_in_s = d;
      req_s     = ~req_s;
   endtask

   initial begin
      rst_n_s   = 1'b0;
      req_s     = 1'b0;
      data_in_s = 32'h0000_0000;
      ready_s   = 1'b0;
`ifdef CDC_HS_RX_ERR_EN
      err_clr_s = 1'b0;
`endif
      for (int i = 0; i < 30; i++) words_r[i] = $urandom;

      // reset
      #200;
      check_val("rst_data", data_out_s, 32'h0000_0000);
      check_val("rst_valid", {31'd0, valid_s}, 32'd0);
      check_val("rst_ack", {31'd0, ack_s}, 32'd0);
`ifdef CDC_HS_RX_ERR_EN
      check_val("rst_err", {31'd0, err_s}, 32'd0);
`endif
      @(negedge clk_s);
      rst_n_s = 1'b1;
      repeat (2) @(negedge clk_s);

      // single transfer, ready tied high
      ready_s = 1'b1;
      send_req(32'hDEAD_BEEF);
      repeat (3) @(posedge clk_s);
      #1 check_val("single_k2_valid", {31'd0, valid_s}, 32'd0);
      @(posedge clk_s); #1;
      check_val("single_k3_valid", {31'd0, valid_s}, 32'd1);
      check_val("single_k3_data", data_out_s, 32'hDEAD_BEEF);
      @(posedge clk_s); #1;
      exp_ack_r = ~exp_ack_r;
      check_val("single_k4_valid", {31'd0, valid_s}, 32'd0);
      check_val("single_k4_ack", {31'd0, ack_s}, {31'd0, exp_ack_r});

      // backpressure
      ready_s = 1'b0;
      send_req(32'hDEAD_BEEF);
      wait_valid("bp_valid_rise", 10);
      data_in_s = 32'h0000_0000;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_s); #1;
         check_val("bp_hold_valid", {31'd0, valid_s}, 32'd1);
         check_val("bp_hold_data", data_out_s, 32'hDEAD_BEEF);
         check_val("bp_hold_ack", {31'd0, ack_s}, {31'd0, exp_ack_r});
      end
      ready_s = 1'b1;
      @(posedge clk_s); #1;
      exp_ack_r = ~exp_ack_r;
      check_val("bp_accept_valid", {31'd0, valid_s}, 32'd0);
      check_val("bp_accept_ack", {31'd0, ack_s}, {31'd0, exp_ack_r});
      ready_s = 1'b0;
      repeat (2) @(negedge clk_s);

      // stream: 20 MHz source waiting for each ack, sink with random backpressure
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               int t;
               @(posedge src_clk_s);
               data_in_s = words_r[i];
               req_s     = ~req_s;
               t = 0;
               while (ack_s !== req_s && t < 200) begin
                  @(posedge src_clk_s);
                  t++;
               end
               check_val("stream_src_ack", {31'd0, ack_s}, {31'd0, req_s});
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               wait_valid("stream_valid", 400);
               check_val("stream_data", data_out_s, words_r[i]);
               repeat ($urandom_range(0, 3)) @(posedge clk_s);
               #1 ready_s = 1'b1;
               @(posedge clk_s); #1;
               ready_s = 1'b0;
            end
            @(posedge clk_s); #1;
            stream_done_r = 1'b1;
         end
         begin
            logic prev;
            prev = ack_s;
            while (!stream_done_r) begin
               @(posedge clk_s); #1;
               if (ack_s !== prev) begin
                  ack_cnt_r++;
                  prev = ack_s;
               end
            end
         end
      join
      check_val("stream_ack_count", ack_cnt_r, 32'd30);
      check_val("stream_ack_level", {31'd0, ack_s}, {31'd0, exp_ack_r});

      // violation: second toggle while VALID and not ready
      ready_s = 1'b0;
      send_req(32'h1111_2222);
      wait_valid("viol_valid", 10);
      check_val("viol_first_data", data_out_s, 32'h1111_2222);
      send_req(32'h3333_4444);
      repeat (6) @(posedge clk_s);
      #1 check_val("viol_hold_data", data_out_s, 32'h1111_2222);
      check_val("viol_hold_valid", {31'd0, valid_s}, 32'd1);
`ifdef CDC_HS_RX_ERR_EN
      check_val("viol_err_set", {31'd0, err_s}, 32'd1);
`endif
      ready_s = 1'b1;
      @(posedge clk_s); #1;
      exp_ack_r = ~exp_ack_r;
      check_val("viol_accept_valid", {31'd0, valid_s}, 32'd0);
      check_val("viol_accept_ack", {31'd0, ack_s}, {31'd0, exp_ack_r});
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_s); #1;
         check_val("viol_no_extra_valid", {31'd0, valid_s}, 32'd0);
      end
      check_val("viol_data_after", data_out_s, 32'h1111_2222);
`ifdef CDC_HS_RX_ERR_EN
      check_val("viol_err_sticky", {31'd0, err_s}, 32'd1);
      err_clr_s = 1'b1;
      @(posedge clk_s); #1;
      err_clr_s = 1'b0;
      check_val("viol_err_clr", {31'd0, err_s}, 32'd0);
`endif

      // mid-transfer reset, then a normal transfer
      ready_s = 1'b0;
      send_req(32'h0BAD_F00D);
      wait_valid("mrst_valid", 10);
      #5;
      rst_n_s = 1'b0;
      req_s   = 1'b0;
      exp_ack_r = 1'b0;
      #1;
      check_val("mrst_data", data_out_s, 32'h0000_0000);
      check_val("mrst_valid", {31'd0, valid_s}, 32'd0);
      check_val("mrst_ack", {31'd0, ack_s}, 32'd0);
`ifdef CDC_HS_RX_ERR_EN
      check_val("mrst_err", {31'd0, err_s}, 32'd0);
`endif
      #100;
      @(negedge clk_s);
      rst_n_s = 1'b1;
      repeat (2) @(negedge clk_s);
      ready_s = 1'b1;
      send_req(32'h5A5A_5A5A);
      wait_valid("post_rst_valid", 10);
      check_val("post_rst_data", data_out_s, 32'h5A5A_5A5A);
      @(posedge clk_s); #1;
      check_val("post_rst_valid_fall", {31'd0, valid_s}, 32'd0);
      check_val("post_rst_ack", {31'd0, ack_s}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Destination-side controller for multi-bit clock-domain crossings in the camera-to-VGA path. It synchronizes a single request toggle from the source domain and sequences the capture of a quasi-static data bus. It presents each word on a valid/ready interface in the I_CLK domain and returns an acknowledge toggle to the source. Only the toggle goes through a STAGE-flop synchronizer; the data bus is sampled once it is guaranteed stable.

## Interface
Parameters:
- RST_VAL, 0: reset value of O_DATA.
- STAGE, 3: synchronizer depth on I_REQ_TGL; legal range 2..4.
- DW, 32: data bus width.

Ports:
- I_CLK  input  1  destination clock; the only clock.
- I_RST_N  input  1  asynchronous, active-low reset.
- I_REQ_TGL  input  1  request toggle from the source domain (asynchronous to I_CLK).
- I_DATA  input  DW  source data (asynchronous); held stable by the source from before each I_REQ_TGL edge until O_ACK_TGL is seen.
- I_READY  input  1  downstream ready.
- O_DATA  output  DW  captured word; registered.
- O_VALID  output  1  O_DATA valid; registered.
- O_ACK_TGL  output  1  acknowledge toggle to the source; registered.
- O_ERR  output  1  sticky protocol error. Present only with CDC_HS_RX_ERR_EN.
- I_ERR_CLR  input  1  synchronous clear for O_ERR. Present only with CDC_HS_RX_ERR_EN.

## Operation
- I_REQ_TGL passes through STAGE flops; the output of the last flop is req_s. A further flop, req_d, follows req_s.
- req_edge is defined as req_s XOR req_d. req_d updates every cycle, whatever the state.
- FSM with two states:
  - IDLE: O_VALID=0. If req_edge is 1, capture I_DATA into O_DATA, set O_VALID=1 and go to VALID.
  - VALID: O_VALID=1 and O_DATA is held. When I_READY=1, clear O_VALID, invert O_ACK_TGL and return to IDLE.
- A req_edge while in VALID is a protocol violation, including an edge in the accept cycle itself. It is not queued and the edge is consumed. O_DATA is not overwritten.
- There is no back-to-back capture in the cycle after an accept. A new word needs a new request toggle, which the source cannot issue before it sees O_ACK_TGL.
- Reset values:
  - O_DATA = RST_VAL.
  - O_VALID = 0, O_ACK_TGL = 0, O_ERR = 0.
  - All synchronizer flops, req_d and the FSM clear (FSM to IDLE).
- Reset mid-transfer aborts the word. The source must be reset in the same reset event so that both toggles restart at 0.

## Timing
- Source toggles I_REQ_TGL between I_CLK edges k-1 and k. req_s changes at edge k+STAGE-1. O_VALID rises and O_DATA updates at edge k+STAGE.
- Request-to-valid latency is STAGE+1 edges, worst case including sampling uncertainty.
- Accept happens at a rising edge where O_VALID=1 and I_READY=1. O_VALID falls and O_ACK_TGL toggles at that same edge.
- If I_READY=1 already in IDLE, the word is still held for at least one cycle; O_VALID is high for exactly one cycle.
- O_VALID, once high, stays high and O_DATA stays constant until accept (AXI-style hold).

## Configuration
- CDC_HS_RX_ERR_EN defined:
  - O_ERR and I_ERR_CLR exist.
  - O_ERR is set at the edge after a req_edge observed in VALID and stays set until I_ERR_CLR=1 or reset.
  - If I_ERR_CLR and a new violation occur in the same cycle, set wins.
- CDC_HS_RX_ERR_EN undefined: the ports are absent and violations are silently dropped. All other behaviour is identical.

## Test plan
- Reset: hold I_RST_N=0 for 200 ns with DW=32 and RST_VAL=0 -> O_DATA=0, O_VALID=0, O_ACK_TGL=0. With the macro on, also O_ERR=0.
- Single transfer with I_READY tied 1 and STAGE=3:
  - Stimulus: I_DATA=32'hDEADBEEF, then toggle I_REQ_TGL before edge k.
  - Required: O_VALID=1 with O_DATA=DEADBEEF at edge k+3; O_VALID=0 and O_ACK_TGL=1 at edge k+4.
- Backpressure: I_READY=0 for 10 cycles after O_VALID rises, with I_DATA changed to 32'h0 after the toggle -> O_DATA holds DEADBEEF and O_VALID stays 1. The accept and O_ACK_TGL toggle occur on the first edge with I_READY=1.
- Stream: 30 random words from a 20 MHz source model that waits for each ack, with I_CLK at 25 MHz -> all 30 received in order with no mismatch. O_ACK_TGL toggles 30 times.
- Violation: a second I_REQ_TGL toggle while O_VALID=1 and I_READY=0 -> O_DATA unchanged and no extra O_VALID. With the macro on, O_ERR=1 until I_ERR_CLR is pulsed.
- Mid-transfer reset: assert I_RST_N=0 while in VALID -> all outputs return to their reset values immediately. The next toggle after release transfers normally.
